// File: rtl/cic_pkg.sv
// Shared types and elaboration helpers for the multi-channel PDM CIC decimator.
package cic_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // PDM bit 1 is +1 and bit 0 is -1; sign-extended to the accumulator width at use
    localparam logic signed [1:0] PDM_POS = 2'sb01;
    localparam logic signed [1:0] PDM_NEG = 2'sb11;

    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Bit growth of an ORDER-stage CIC at the largest ratio, plus a sign bit
    function automatic int acc_w_f(input int order, input int r_max);
        return order * clog2_f(r_max) + 1;
    endfunction

endpackage

// File: rtl/cic_comb_chain.sv
// Combinational ORDER-stage comb section with arithmetic shift and output saturation.
// One instance is time-shared across channels; the caller owns the delay registers.
module cic_comb_chain
    import cic_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int ACC_W = 16,
    parameter int OUT_W = 16,
    parameter int SW    = 5
) (
    input  logic signed [ACC_W-1:0]     x,
    input  logic [ORDER-1:0][ACC_W-1:0] dly,
    input  logic [SW-1:0]               shift,
    output logic [ORDER-1:0][ACC_W-1:0] stage_in,
    output logic signed [OUT_W-1:0]     y
);

    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (OUT_W - 1));

    logic signed [ACC_W-1:0] diff_s;
    logic signed [ACC_W-1:0] shifted_s;
    logic signed [63:0]      wide_s;

    // Cascaded differences; each stage input becomes that stage's next delay value
    always_comb begin
        diff_s   = x;
        stage_in = '0;
        for (int k = 0; k < ORDER; k++) begin
            stage_in[k] = diff_s;
            diff_s      = diff_s - $signed(dly[k]);
        end
    end

    // Arithmetic right shift, then clamp into the signed output range
    always_comb begin
        shifted_s = diff_s >>> shift;
        wide_s    = {{(64 - ACC_W){shifted_s[ACC_W-1]}}, shifted_s};
        if (wide_s > SAT_MAX) begin
            y = SAT_MAX[OUT_W-1:0];
        end else if (wide_s < SAT_MIN) begin
            y = SAT_MIN[OUT_W-1:0];
        end else begin
            y = wide_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator for 1-bit PDM inputs: parallel integrators, snapshot bank,
// and a single comb chain sequenced over the channels once per decimation event.
module cic_decim_mc
    import cic_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ORDER    = 3,
    parameter int R_MAX    = 32,
    parameter int RW       = 6,
    parameter int OUT_W    = 16,
    parameter int SW       = 5,
    localparam int CW      = (CHANNELS > 1) ? clog2_f(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    en,
    input  logic [CHANNELS-1:0]     pdm_in,
    input  logic [RW-1:0]           dec_ratio,
    input  logic [SW-1:0]           shift,
    input  logic                    overrun_clr,
    output logic                    out_valid,
    output logic [CW-1:0]           out_ch,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    overrun
);

    localparam int            ACC_W   = acc_w_f(ORDER, R_MAX);
    localparam logic [RW-1:0] R_ONE   = {{(RW - 1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] R_MIN_V = {{(RW - 2){1'b0}}, 2'b10};
    localparam logic [RW-1:0] R_MAX_V = RW'(R_MAX);
    localparam logic [CW-1:0] CH_ONE  = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    logic signed [ACC_W-1:0]     integ_r [CHANNELS][ORDER];
    logic signed [ACC_W-1:0]     pdm_x_s [CHANNELS];
    logic signed [ACC_W-1:0]     snap_r  [CHANNELS];
    logic [ORDER-1:0][ACC_W-1:0] dly_r   [CHANNELS];
    logic [RW-1:0]               cnt_r;
    logic [RW-1:0]               r_eff_r;
    logic [RW-1:0]               r_clamp_s;
    seq_state_t                  state_r;
    logic [CW-1:0]               ch_idx_r;
    logic                        dec_ev_s;
    logic                        last_s;
    logic                        ovr_set_s;
    logic [ORDER-1:0][ACC_W-1:0] stage_in_s;
    logic signed [OUT_W-1:0]     comb_y_s;

    // Ratio clamp, decimation-event decode and overrun condition
    always_comb begin
        if (dec_ratio < R_MIN_V) begin
            r_clamp_s = R_MIN_V;
        end else if (dec_ratio > R_MAX_V) begin
            r_clamp_s = R_MAX_V;
        end else begin
            r_clamp_s = dec_ratio;
        end
        dec_ev_s  = ce & en & (cnt_r == (r_eff_r - R_ONE));
        last_s    = (ch_idx_r == LAST_CH);
        ovr_set_s = dec_ev_s & (state_r == RUN) & ~last_s;
    end

    // PDM bit to signed +/-1 at accumulator width
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (pdm_in[c]) begin
                pdm_x_s[c] = ACC_W'(PDM_POS);
            end else begin
                pdm_x_s[c] = ACC_W'(PDM_NEG);
            end
        end
    end

    // Integrator cascade; wrap-around is intended and cancelled by the combs
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_r[c][k] <= '0;
                end
            end
        end else if (ce) begin
            for (int c = 0; c < CHANNELS; c++) begin
                integ_r[c][0] <= integ_r[c][0] + pdm_x_s[c];
                for (int k = 1; k < ORDER; k++) begin
                    integ_r[c][k] <= integ_r[c][k] + integ_r[c][k-1];
                end
            end
        end
    end

    // Decimation counter; the effective ratio is only reloaded at a wrap or a clear
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_r   <= '0;
            r_eff_r <= r_clamp_s;
        end else if (ce) begin
            if (dec_ev_s) begin
                cnt_r   <= '0;
                r_eff_r <= r_clamp_s;
            end else begin
                cnt_r <= cnt_r + R_ONE;
            end
        end
    end

    // Sequencer: snapshot on an event, then one channel per clock through the comb.
    // An event on the last channel chains straight into the next sequence.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_r   <= IDLE;
            ch_idx_r  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                snap_r[c] <= '0;
                dly_r[c]  <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (dec_ev_s) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            snap_r[c] <= integ_r[c][ORDER-1];
                        end
                        state_r  <= RUN;
                        ch_idx_r <= '0;
                    end
                end
                RUN: begin
                    out_valid       <= 1'b1;
                    out_ch          <= ch_idx_r;
                    out_data        <= comb_y_s;
                    dly_r[ch_idx_r] <= stage_in_s;
                    if (!last_s) begin
                        ch_idx_r <= ch_idx_r + CH_ONE;
                    end else if (dec_ev_s) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            snap_r[c] <= integ_r[c][ORDER-1];
                        end
                        ch_idx_r <= '0;
                    end else begin
                        state_r  <= IDLE;
                        ch_idx_r <= '0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ch_idx_r <= '0;
                end
            endcase
        end
    end

    cic_comb_chain #(
        .ORDER (ORDER),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SW    (SW)
    ) u_comb (
        .x        (snap_r[ch_idx_r]),
        .dly      (dly_r[ch_idx_r]),
        .shift    (shift),
        .stage_in (stage_in_s),
        .y        (comb_y_s)
    );

    // Sticky overrun; survives en=0, and a set beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ovr_set_s) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Directed bench: a 2-channel 16-bit instance and a 4-channel 8-bit instance share controls.
module tb_cic_decim_mc;

    logic       clk = 1'b0;
    logic       rst, ce, en, overrun_clr;
    logic [1:0] pdm_a;
    logic [3:0] pdm_b;
    logic [5:0] dec_ratio;
    logic [4:0] shift;

    logic        va, vb, ova, ovb;
    logic [0:0]  cha;
    logic [1:0]  chb;
    logic [15:0] da;
    logic [7:0]  db;

    cic_decim_mc #(.CHANNELS(2), .ORDER(3), .R_MAX(32), .RW(6), .OUT_W(16), .SW(5)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .en(en), .pdm_in(pdm_a), .dec_ratio(dec_ratio),
        .shift(shift), .overrun_clr(overrun_clr), .out_valid(va), .out_ch(cha),
        .out_data(da), .overrun(ova));

    cic_decim_mc #(.CHANNELS(4), .ORDER(3), .R_MAX(32), .RW(6), .OUT_W(8), .SW(5)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .en(en), .pdm_in(pdm_b), .dec_ratio(dec_ratio),
        .shift(shift), .overrun_clr(overrun_clr), .out_valid(vb), .out_ch(chb),
        .out_data(db), .overrun(ovb));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ce / PDM pattern generator
    int         ce_div = 4;
    logic       ce_on  = 1'b1;
    logic       alt    = 1'b0;
    logic       tog    = 1'b0;
    logic [1:0] pat_a  = 2'b00;
    logic [3:0] pat_b  = 4'b0000;
    int         phase  = 0;

    initial begin
        ce    = 1'b0;
        pdm_a = 2'b00;
        pdm_b = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (ce_on && phase >= ce_div - 1) begin
                ce    = 1'b1;
                phase = 0;
                tog   = ~tog;
            end else begin
                ce = 1'b0;
                if (ce_on) phase++;
            end
            pdm_a = alt ? {2{tog}} : pat_a;
            pdm_b = alt ? {4{tog}} : pat_b;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    int   last_a [2];
    int   cnt_a  [2];
    int   last_b [4];
    logic log_en = 1'b0;
    int   log_n  = 0;
    int   log_ch [64];
    int   log_d  [64];
    int   log_c  [64];

    initial begin
        cnt_a[0] = 0; cnt_a[1] = 0;
        last_a[0] = 0; last_a[1] = 0;
        for (int i = 0; i < 4; i++) last_b[i] = 0;
    end

    always @(negedge clk) begin
        if (va) begin
            last_a[cha] <= int'($signed(da));
            cnt_a[cha]  <= cnt_a[cha] + 1;
        end
        if (vb) begin
            last_b[chb] <= int'($signed(db));
            if (log_en && log_n < 64) begin
                log_ch[log_n] <= int'(chb);
                log_d[log_n]  <= int'($signed(db));
                log_c[log_n]  <= cyc;
                log_n         <= log_n + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Wait for n more outputs of channel ch on instance A (bounded)
    task automatic wait_a(input int ch, input int n);
        int target;
        target = cnt_a[ch] + n;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (cnt_a[ch] >= target) return;
        end
        total++;
        bad++;
        $display("FAIL timeout_ch%0d: actual=no_output expected=%0d_outputs", ch, n);
    endtask

    typedef struct {
        logic [1:0] pa;
        logic [3:0] pb;
        logic       alt;
        logic [5:0] ratio;
        logic [4:0] sh;
        int         ea0;
        int         ea1;
        int         eb0;
        int         eb3;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int t0, t1, t2, base;

        vecs[0] = '{2'b01, 4'b0001, 1'b0, 6'd8,  5'd0, 512,    -512,   127,  -128};
        vecs[1] = '{2'b00, 4'b0000, 1'b1, 6'd8,  5'd0, 0,      0,      0,    0};
        vecs[2] = '{2'b11, 4'b1111, 1'b0, 6'd8,  5'd2, 128,    128,    127,  127};
        vecs[3] = '{2'b11, 4'b1111, 1'b0, 6'd8,  5'd3, 64,     64,     64,   64};
        vecs[4] = '{2'b00, 4'b0000, 1'b0, 6'd8,  5'd0, -512,   -512,   -128, -128};
        vecs[5] = '{2'b11, 4'b1111, 1'b0, 6'd16, 5'd0, 4096,   4096,   127,  127};
        vecs[6] = '{2'b11, 4'b1111, 1'b0, 6'd1,  5'd0, 8,      8,      8,    8};
        vecs[7] = '{2'b00, 4'b0000, 1'b0, 6'd40, 5'd0, -32768, -32768, -128, -128};
        vecs[8] = '{2'b00, 4'b0000, 1'b0, 6'd40, 5'd5, -1024,  -1024,  -128, -128};

        rst = 1'b1; en = 1'b1; overrun_clr = 1'b0; dec_ratio = 6'd8; shift = 5'd0;
        pat_a = 2'b01; pat_b = 4'b0001;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", int'(va), 0);
        check("rst_ch", int'(cha), 0);
        check("rst_data", int'($signed(da)), 0);
        check("rst_ovr_a", int'(ova), 0);
        check("rst_ovr_b", int'(ovb), 0);
        rst = 1'b0;

        // Clean start: 4th decimated output is settled; channel pulses are adjacent
        wait_a(0, 4);
        check("clean_4th_ch0", last_a[0], 512);
        @(negedge clk); #1;
        check("adj_ch1_pulse", int'({va, cha}), 3);
        @(negedge clk); #1;
        check("adj_gap_after", int'(va), 0);
        check("clean_ch1", last_a[1], -512);

        // Steady-state vectors
        ce_div = 4;
        for (int v = 0; v < 9; v++) begin
            pat_a = vecs[v].pa; pat_b = vecs[v].pb; alt = vecs[v].alt;
            dec_ratio = vecs[v].ratio; shift = vecs[v].sh;
            wait_a(1, 8);
            repeat (4) @(negedge clk);
            #1;
            check($sformatf("vec%0d_a0", v), last_a[0], vecs[v].ea0);
            check($sformatf("vec%0d_a1", v), last_a[1], vecs[v].ea1);
            check($sformatf("vec%0d_b0", v), last_b[0], vecs[v].eb0);
            check($sformatf("vec%0d_b3", v), last_b[3], vecs[v].eb3);
        end
        check("no_ovr_b_vectors", int'(ovb), 0);
        alt = 1'b0;

        // Ratio change mid-block takes effect only at the next wrap
        pat_a = 2'b11; pat_b = 4'b1111; dec_ratio = 6'd8; shift = 5'd0;
        wait_a(0, 6);
        wait_a(0, 1);
        t0 = cyc;
        dec_ratio = 6'd16;
        wait_a(0, 1);
        t1 = cyc;
        wait_a(0, 1);
        t2 = cyc;
        check("ratio_gap_old", t1 - t0, 32);
        check("ratio_gap_new", t2 - t1, 64);
        wait_a(0, 6);
        check("ratio16_settled", last_a[0], 4096);

        // Overrun: 4 channels, ce every clk, R=2
        rst = 1'b1; ce_div = 1; dec_ratio = 6'd2; pat_a = 2'b11; pat_b = 4'b1111;
        @(negedge clk); #1;
        log_en = 1'b1;
        base = log_n;
        rst = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovr_seq_ch%0d", i), log_ch[base + i], i);
            check($sformatf("ovr_seq_cyc%0d", i), log_c[base + i] - log_c[base], i);
            check($sformatf("ovr_seq_data%0d", i), log_d[base + i], log_d[base]);
        end
        log_en = 1'b0;
        check("ovr_set_b", int'(ovb), 1);
        check("ovr_chain_a", int'(ova), 0);
        ce_on = 1'b0;
        repeat (8) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk); #1;
        overrun_clr = 1'b0;
        check("ovr_cleared", int'(ovb), 0);
        ce_on = 1'b1;
        repeat (16) @(negedge clk);
        #1;
        check("ovr_reset_again", int'(ovb), 1);

        // en=0 during RUN: outputs stop, overrun kept, clean restart
        ce_div = 4; dec_ratio = 6'd8; pat_a = 2'b01;
        wait_a(0, 3);
        wait_a(0, 1);
        en = 1'b0;
        @(negedge clk); #1;
        check("en_drop_valid", int'(va), 0);
        check("en_keeps_ovr", int'(ovb), 1);
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_a(0, 4);
        check("en_restart_4th", last_a[0], 512);

        // rst during RUN: outputs stop, overrun cleared, clean restart
        wait_a(0, 1);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rst_run_valid", int'(va), 0);
        check("rst_run_ovr_b", int'(ovb), 0);
        rst = 1'b0;
        wait_a(0, 4);
        check("rst_restart_4th", last_a[0], 512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cic_decim_mc.md
Name: cic_decim_mc

Overview:
- Multi-channel, parametrised CIC decimator for 1-bit PDM microphone streams. It generalises the single-channel fixed CIC in the mic datapath.
- Sits between micclk (supplies ce at the PDM bit rate) and the downstream pcm_clk/FIR_Filter stage.
- Adds runtime decimation ratio, runtime output shift with saturation, N channels, a time-multiplexed comb section and overrun detection.

Parameters:
- CHANNELS, 2, number of PDM inputs.
- ORDER, 3, CIC order (integrator and comb stage count), 1..5.
- R_MAX, 32, maximum decimation ratio, power of two.
- RW, 6, width of dec_ratio; must hold R_MAX.
- OUT_W, 16, signed output width.
- SW, 5, width of shift.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  PDM bit strobe, one clk wide
- en  in  1  run enable; low synchronously clears datapath state
- pdm_in  in  CHANNELS  PDM bits, sampled when ce=1
- dec_ratio  in  RW  decimation ratio R, 2..R_MAX
- shift  in  SW  arithmetic right shift applied before saturation
- overrun_clr  in  1  clears overrun
- out_valid  out  1  one-cycle pulse per channel sample
- out_ch  out  clog2(CHANNELS)  channel index of out_data
- out_data  out  OUT_W  signed decimated sample
- overrun  out  1  sticky overrun flag

Behaviour:
- ACC_W = ORDER*clog2(R_MAX)+1. All integrator and comb arithmetic is two's complement at ACC_W. Integrator wrap-around is intentional; no saturation is applied inside the CIC.
- PDM mapping: bit 1 -> +1, bit 0 -> -1, sign-extended to ACC_W.
- Reset (rst=1), or en=0:
  - Integrators, comb delay registers, decimation counter and sequencer are cleared.
  - out_valid=0, out_ch=0, out_data=0.
  - overrun is cleared by rst only, not by en=0.
- Integrators: on each clk with ce=1 and en=1, every channel's ORDER cascaded integrators update in parallel. Stage k adds the registered output of stage k-1.
- Decimation counter:
  - Counts ce pulses 0..R_eff-1.
  - R_eff is latched from dec_ratio when the counter wraps and at reset. Values <2 are treated as 2; values >R_MAX are treated as R_MAX.
  - A decimation event is the ce cycle in which the counter equals R_eff-1. The counter returns to 0 on that cycle.
- Snapshot: at the clock edge of a decimation event (edge E), the final integrator outputs of all channels are copied into a snapshot bank. The sequencer then goes IDLE->RUN with ch_idx=0.
- Sequencer FSM:
  - IDLE: waits for a decimation event.
  - RUN: processes one channel per clk. The ORDER-stage comb chain is combinational: y = x - x_delay per stage, with per-channel delay registers. Delay registers for ch_idx update at the same edge.
  - The result is arithmetic-shifted right by shift, then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_valid/out_ch/out_data are registered. Channel k appears in the cycle following edge E+1+k.
  - After ch_idx=CHANNELS-1 the FSM returns to IDLE.
- Overrun:
  - A decimation event while the FSM is in RUN and will not be in IDLE at that same edge sets overrun=1.
  - The new snapshot is dropped. The current sequence completes unchanged and the integrators keep running.
  - overrun_clr=1 clears the flag. A simultaneous set wins.
- Throughput requirement on the system: CHANNELS clk cycles fit inside R_eff ce periods.
- dec_ratio changes mid-block take effect only at the next wrap. shift is used combinationally at the time of each output.

Decomposition:
- Package cic_pkg holds the ACC_W derivation function, the clog2 helper, the sequencer state enum (IDLE, RUN) and the PDM-to-signed mapping constants.
- One natural sub-module, cic_comb_chain: a combinational ORDER-stage comb with per-stage subtract and saturate/shift output. It is instantiated once and shared across channels by the sequencer.

Test Plan:
- Setup: CHANNELS=2, ORDER=3, R=8, shift=0, OUT_W=16, ce every 4 clk.
  - ch0 all ones, ch1 all zeros -> from the 4th decimated output onward, ch0=+512 and ch1=-512. out_ch sequence is 0,1 and the pulses fall on consecutive cycles.
  - Alternating 1,0 PDM on both channels -> settled outputs equal 0.
- Saturation: OUT_W=8, shift=0, all ones -> 127. Same input with shift=2 -> 127 (512>>2=128, saturated). Same input with shift=3 -> 64.
- Overrun: CHANNELS=4, ce every clk, R=2 -> overrun=1 after the second event; the first 4-sample sequence completes intact; overrun_clr clears the flag.
- Ratio change: dec_ratio switched 8->16 mid-block -> the current block still uses 8. Output spacing then becomes 16 ce. The settled all-ones value becomes 4096, which saturates to 32767? No: 4096 fits in 16 bits, so the settled value is 4096.
- Reset/en mid-RUN: assert rst during channel 1 output -> out_valid=0 on the next cycle and overrun=0. After release, the first settled value matches the clean-start run. en=0 gives the same result but preserves overrun.
